// File: rtl/arbiter_pkg.sv
// Package: arbiter_pkg
// Purpose : Shared helpers for the round-robin arbiter.
// Contents:
//   ARB_MAX_W     - widest vector the helpers accept (REQ_WIDTH must not exceed it)
//   onehot_to_idx - index of the set bit in a one-hot vector (0 when all-zero)
package arbiter_pkg;

    localparam int ARB_MAX_W = 32;

    // Returns the position of the set bit. For an all-zero vector it returns 0;
    // callers qualify the result with their own valid flag.
    function automatic int onehot_to_idx(input logic [ARB_MAX_W-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_rr_prio_sel.sv
// Module : arbiter_rr_prio_sel
// Purpose: Purely combinational round-robin winner selection. The request
//          vector is rotated so that bit `ptr` lands at position 0, the lowest
//          set bit is isolated, and the result is rotated back.
// Ports  :
//   req   [REQ_WIDTH] in  - request vector
//   ptr   [PTR_W]     in  - index of the highest-priority requester (< REQ_WIDTH)
//   win   [REQ_WIDTH] out - one-hot winner, all-zero when no request
//   valid             out - at least one request is present
module arbiter_rr_prio_sel #(
    parameter int REQ_WIDTH = 8,
    parameter int PTR_W     = $clog2(REQ_WIDTH)
) (
    input  logic [REQ_WIDTH-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [REQ_WIDTH-1:0] win,
    output logic                 valid
);

    logic [REQ_WIDTH-1:0] rot;
    logic [REQ_WIDTH-1:0] rot_lo;

    always_comb begin
        // Rotate right by ptr. With ptr == 0 the left shift is by REQ_WIDTH
        // and contributes nothing, which is the desired identity rotation.
        rot    = (req >> ptr) | (req << (REQ_WIDTH - int'(ptr)));
        // Two's-complement trick keeps only the lowest set bit.
        rot_lo = rot & (~rot + REQ_WIDTH'(1));
        // Rotate left by ptr to return to original bit positions.
        win    = (rot_lo << ptr) | (rot_lo >> (REQ_WIDTH - int'(ptr)));
        valid  = |req;
    end

endmodule

// File: rtl/arbiter.sv
// Module : arbiter
// Purpose: Round-robin arbiter granting at most one of REQ_WIDTH requesters
//          per clock. The grant is registered (no combinational req->gnt
//          path) and priority rotates to the requester after the last winner.
// Ports  :
//   clk               in  - rising-edge clock
//   reset             in  - asynchronous active-low reset (gnt=0, ptr=0)
//   req   [REQ_WIDTH] in  - request vector
//   gnt   [REQ_WIDTH] out - registered one-hot grant, or all-zero
// REQ_WIDTH must be in 2..ARB_MAX_W.
module arbiter
    import arbiter_pkg::*;
#(
    parameter int REQ_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REQ_WIDTH-1:0] req,
    output logic [REQ_WIDTH-1:0] gnt
);

    localparam int PTR_W = $clog2(REQ_WIDTH);

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
    logic [REQ_WIDTH-1:0] win;
    logic                 win_vld;
    logic [ARB_MAX_W-1:0] win_ext;
    int                   win_idx;

    arbiter_rr_prio_sel #(
        .REQ_WIDTH (REQ_WIDTH),
        .PTR_W     (PTR_W)
    ) u_rr_prio_sel (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_vld)
    );

    always_comb begin
        win_ext                = '0;
        win_ext[REQ_WIDTH-1:0] = win;
        win_idx                = onehot_to_idx(win_ext);

        gnt_d = '0;
        ptr_d = ptr_q;
        if (win_vld) begin
            gnt_d = win;
            // Explicit wrap so non-power-of-two widths never reach 2^PTR_W.
            if (win_idx == REQ_WIDTH - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = PTR_W'(win_idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt = gnt_q;

endmodule

// File: tb/tb_arbiter.sv
module tb_arbiter;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [4:0] req5;
    logic [4:0] gnt5;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q  [$];
    logic [4:0] exp5_q [$];

    arbiter #(.REQ_WIDTH(8)) u_dut (
        .clk   (clk),
        .reset (reset_n),
        .req   (req),
        .gnt   (gnt)
    );

    // Non-power-of-two instance exercises wrap at REQ_WIDTH.
    arbiter #(.REQ_WIDTH(5)) u_dut5 (
        .clk   (clk),
        .reset (reset_n),
        .req   (req5),
        .gnt   (gnt5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: each edge, compare the registered grant with the
    // oldest outstanding expectation.
    always @(posedge clk) begin
        logic [7:0] e;
        logic [4:0] e5;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt", {24'h0, gnt}, {24'h0, e});
            chk("gnt_onehot0", {31'h0, $onehot0(gnt)}, 32'h1);
        end
        if (exp5_q.size() > 0) begin
            e5 = exp5_q.pop_front();
            chk("gnt5", {27'h0, gnt5}, {27'h0, e5});
        end
    end

    // Apply a request at the falling edge; the next rising edge must produce e.
    task automatic step(input logic [7:0] r, input logic [7:0] e);
        @(negedge clk);
        req = r;
        exp_q.push_back(e);
    endtask

    // Reset pulse wholly between edges, with requests idle so ptr stays 0.
    task automatic pulse_reset();
        @(negedge clk);
        req  = 8'h00;
        req5 = 5'h00;
        #2;
        reset_n = 1'b0;
        #1;
        chk("pulse_rst_gnt", {24'h0, gnt}, 32'h0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = 8'hFF;
        req5    = 5'h00;

        // Reset held with all requests active: grant stays clear.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", {24'h0, gnt}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(8'h01);

        // Directed sequence from reset.
        pulse_reset();
        step(8'h01, 8'h01);
        step(8'h05, 8'h04);
        step(8'h09, 8'h08);
        step(8'h39, 8'h10);
        step(8'h39, 8'h20);
        step(8'h39, 8'h01);
        step(8'h09, 8'h08);
        // Idle keeps ptr (last winner bit 3).
        step(8'h00, 8'h00);
        step(8'h00, 8'h00);
        step(8'h00, 8'h00);
        step(8'hFF, 8'h10);
        // Sole requester, then wrap-around.
        step(8'h80, 8'h80);
        step(8'h80, 8'h80);
        step(8'h80, 8'h80);
        step(8'h80, 8'h80);
        step(8'h81, 8'h01);

        // Fairness from reset: 01..80 twice.
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            step(8'hFF, 8'(1 << (i % 8)));
        end

        // Asynchronous reset while gnt = 20.
        step(8'h20, 8'h20);
        @(posedge clk);
        #2;
        chk("pre_async_gnt", {24'h0, gnt}, 32'h20);
        reset_n = 1'b0;
        #1;
        chk("async_rst_gnt", {24'h0, gnt}, 32'h0);
        req = 8'hFF;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(8'h01);

        // Non-power-of-two width: wraps after bit 4.
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req5 = 5'h1F;
            exp5_q.push_back(5'(1 << (i % 5)));
        end
        @(negedge clk);
        req5 = 5'h11;
        exp5_q.push_back(5'h01);
        @(negedge clk);
        req5 = 5'h11;
        exp5_q.push_back(5'h10);

        @(posedge clk);
        #2;
        chk("drain", exp_q.size() + exp5_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
